// File: rtl/mem_access.sv
// mem_access: pipeline stage between execute and writeback.
//   - Registers ALU / compare results into a one-cycle writeback bundle.
//   - Runs loads and stores on the data memory over a req/ack handshake and
//     holds the upstream stage (stall) while an access is outstanding.
//   - Aborts an access after TIMEOUT cycles without ack and raises the
//     sticky mem_err flag.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   ex_*                  execute bundle (valid, result, flags, rd, address, op kind)
//   stall                 upstream hold, decoded from the state register
//   dmem_*                data memory request/response handshake
//   wb_*                  registered writeback bundle (register file and CPSR)
//   mem_err               sticky timeout flag
module mem_access #(
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_result,
    input  logic [31:0]           ex_cpsr,
    input  logic [3:0]            ex_rd_num,
    input  logic [31:0]           ex_rd_val,
    input  logic [31:0]           ex_mem,
    input  logic                  ex_is_alu_op,
    input  logic                  ex_is_cmp_op,
    input  logic                  ex_is_ld_op,
    input  logic                  ex_is_str_op,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  wb_valid,
    output logic                  wb_reg_we,
    output logic [3:0]            wb_rd_num,
    output logic [31:0]           wb_data,
    output logic                  wb_cpsr_we,
    output logic [31:0]           wb_cpsr,
    output logic                  mem_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  is_ld_q, is_ld_d;
    logic [3:0]            rd_q, rd_d;
    logic                  dmem_req_q, dmem_req_d;
    logic                  dmem_we_q, dmem_we_d;
    logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]           dmem_wdata_q, dmem_wdata_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_reg_we_q, wb_reg_we_d;
    logic [3:0]            wb_rd_num_q, wb_rd_num_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic                  wb_cpsr_we_q, wb_cpsr_we_d;
    logic [31:0]           wb_cpsr_q, wb_cpsr_d;
    logic                  mem_err_q, mem_err_d;

    logic                  mem_op;
    logic                  timeout_hit;

    // Upper address bits and upper CPSR bits are intentionally dropped.
    logic                  unused_bits;
    assign unused_bits = ^{ex_mem[31:ADDR_WIDTH], ex_cpsr[31:4]};

    assign mem_op      = ex_is_ld_op | ex_is_str_op;
    // An ack on the last counted cycle takes priority over the abort.
    assign timeout_hit = (cnt_q == CNT_LAST) && !dmem_ack;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (ex_valid && mem_op) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_ack || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d        = cnt_q;
        is_ld_d      = is_ld_q;
        rd_d         = rd_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_reg_we_d  = 1'b0;
        wb_cpsr_we_d = 1'b0;
        wb_rd_num_d  = wb_rd_num_q;
        wb_data_d    = wb_data_q;
        wb_cpsr_d    = wb_cpsr_q;
        mem_err_d    = mem_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (mem_op) begin
                        // Load wins when both ld and str are flagged.
                        cnt_d        = '0;
                        is_ld_d      = ex_is_ld_op;
                        rd_d         = ex_rd_num;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = ex_is_str_op & ~ex_is_ld_op;
                        dmem_addr_d  = ex_mem[ADDR_WIDTH-1:0];
                        dmem_wdata_d = ex_rd_val;
                    end else begin
                        wb_valid_d   = 1'b1;
                        wb_reg_we_d  = ex_is_alu_op;
                        wb_cpsr_we_d = ex_is_cmp_op;
                        wb_rd_num_d  = ex_rd_num;
                        wb_data_d    = ex_result;
                        wb_cpsr_d    = {28'd0, ex_cpsr[3:0]};
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    dmem_req_d  = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_reg_we_d = is_ld_q;
                    wb_rd_num_d = rd_q;
                    if (is_ld_q) begin
                        wb_data_d = dmem_rdata;
                    end
                end else if (timeout_hit) begin
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    mem_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            is_ld_q      <= 1'b0;
            rd_q         <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_reg_we_q  <= 1'b0;
            wb_rd_num_q  <= '0;
            wb_data_q    <= '0;
            wb_cpsr_we_q <= 1'b0;
            wb_cpsr_q    <= '0;
            mem_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            is_ld_q      <= is_ld_d;
            rd_q         <= rd_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_reg_we_q  <= wb_reg_we_d;
            wb_rd_num_q  <= wb_rd_num_d;
            wb_data_q    <= wb_data_d;
            wb_cpsr_we_q <= wb_cpsr_we_d;
            wb_cpsr_q    <= wb_cpsr_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign stall      = (state_q == S_WAIT);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_reg_we  = wb_reg_we_q;
    assign wb_rd_num  = wb_rd_num_q;
    assign wb_data    = wb_data_q;
    assign wb_cpsr_we = wb_cpsr_we_q;
    assign wb_cpsr    = wb_cpsr_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: randomized and directed execute bundles, a
// memory responder with its own storage, and a writeback scoreboard fed
// from a reference model of the stage's rules.
module tb_mem_access;

    localparam int unsigned AW = 22;
    localparam int unsigned TO = 16;

    logic        clk, rst_n;
    logic        ex_valid;
    logic [31:0] ex_result, ex_cpsr, ex_rd_val, ex_mem;
    logic [3:0]  ex_rd_num;
    logic        ex_is_alu_op, ex_is_cmp_op, ex_is_ld_op, ex_is_str_op;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [AW-1:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_reg_we, wb_cpsr_we, mem_err;
    logic [3:0]  wb_rd_num;
    logic [31:0] wb_data, wb_cpsr;

    mem_access #(.ADDR_WIDTH(AW), .TIMEOUT(TO), .CNT_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_cpsr(ex_cpsr),
        .ex_rd_num(ex_rd_num), .ex_rd_val(ex_rd_val), .ex_mem(ex_mem),
        .ex_is_alu_op(ex_is_alu_op), .ex_is_cmp_op(ex_is_cmp_op),
        .ex_is_ld_op(ex_is_ld_op), .ex_is_str_op(ex_is_str_op),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_reg_we(wb_reg_we), .wb_rd_num(wb_rd_num),
        .wb_data(wb_data), .wb_cpsr_we(wb_cpsr_we), .wb_cpsr(wb_cpsr),
        .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        reg_we;
        bit        cpsr_we;
        bit [3:0]  rd;
        bit [31:0] data;
        bit [31:0] cpsr;
        bit        err;
        bit        is_mem;
    } wb_t;

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
        int        delay;
        bit        noack;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   err_model = 1'b0;
    bit [31:0] ref_mem [int unsigned];
    bit [31:0] bus_mem [int unsigned];

    function automatic bit [31:0] init_word(int unsigned a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic bit [31:0] ref_read(int unsigned a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic bit [31:0] bus_read(int unsigned a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one bundle; it is accepted on the first edge where stall is low.
    task automatic issue(input bit alu, input bit cmp, input bit ld, input bit str,
                         input bit [3:0] rd, input bit [31:0] result, input bit [31:0] cpsr,
                         input bit [31:0] rd_val, input bit [31:0] mem,
                         input int delay, input bit noack);
        int n;
        wb_t w;
        req_t r;
        int unsigned a;
        ex_valid = 1'b1; ex_is_alu_op = alu; ex_is_cmp_op = cmp;
        ex_is_ld_op = ld; ex_is_str_op = str; ex_rd_num = rd;
        ex_result = result; ex_cpsr = cpsr; ex_rd_val = rd_val; ex_mem = mem;
        n = 0;
        while (stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            check("issue_wait_bound", 32'd1, 32'd0);
            return;
        end
        w = '{default: 0};
        if (ld || str) begin
            a = mem % (32'd1 << AW);
            r.we = str && !ld; r.addr = a; r.wdata = rd_val;
            r.delay = delay; r.noack = noack;
            req_q.push_back(r);
            w.is_mem = 1'b1;
            if (noack) begin
                err_model = 1'b1;
            end else if (ld) begin
                w.reg_we = 1'b1; w.rd = rd; w.data = ref_read(a);
            end else begin
                ref_mem[a] = rd_val;
            end
        end else begin
            w.reg_we = alu; w.cpsr_we = cmp; w.rd = rd;
            w.data = result; w.cpsr = cpsr % 16;
        end
        w.err = err_model;
        wb_q.push_back(w);
        @(negedge clk);
    endtask

    task automatic bubble();
        ex_valid = 1'b0;
        ex_is_alu_op = $urandom_range(0, 1); ex_is_cmp_op = $urandom_range(0, 1);
        ex_is_ld_op = $urandom_range(0, 1); ex_is_str_op = $urandom_range(0, 1);
        ex_result = $urandom; ex_mem = $urandom;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        ex_valid = 1'b0;
        n = 0;
        while ((wb_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", wb_q.size(), 0);
    endtask

    // Memory responder: checks each request against the model and acks it.
    initial begin : responder
        bit   busy;
        int   cyc;
        req_t cur;
        busy = 1'b0; cyc = 0; cur = '{default: 0};
        dmem_ack = 1'b0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            if (!rst_n) begin
                busy = 1'b0;
                continue;
            end
            if (dmem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cyc = 0;
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                        cur = '{default: 0};
                    end else begin
                        cur = req_q.pop_front();
                    end
                end
                check("req_we", dmem_we, cur.we);
                check("req_addr", dmem_addr, cur.addr);
                if (cur.we) check("req_wdata", dmem_wdata, cur.wdata);
                check("stall_in_access", stall, 1);
                if (!cur.noack && cyc == cur.delay) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) bus_mem[dmem_addr] = dmem_wdata;
                    else dmem_rdata = bus_read(dmem_addr);
                end
                cyc++;
            end else begin
                if (busy) begin
                    busy = 1'b0;
                    if (cur.noack) check("req_cycles_to_timeout", cyc, TO);
                end
                // Acks outside an access must be ignored.
                if ($urandom_range(0, 7) == 0) dmem_ack = 1'b1;
            end
        end
    end

    // Writeback monitor.
    initial begin : monitor
        wb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wb_valid) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_wb", 32'd1, 32'd0);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_reg_we", wb_reg_we, e.reg_we);
                    check("wb_cpsr_we", wb_cpsr_we, e.cpsr_we);
                    if (e.reg_we) begin
                        check("wb_rd_num", wb_rd_num, e.rd);
                        check("wb_data", wb_data, e.data);
                    end
                    if (e.cpsr_we) check("wb_cpsr", wb_cpsr, e.cpsr);
                    check("mem_err", mem_err, e.err);
                    if (e.is_mem) check("stall_after_access", stall, 0);
                end
            end
        end
    end

    initial begin : main
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_result = '0; ex_cpsr = '0; ex_rd_num = '0;
        ex_rd_val = '0; ex_mem = '0;
        ex_is_alu_op = 1'b0; ex_is_cmp_op = 1'b0; ex_is_ld_op = 1'b0; ex_is_str_op = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_dmem_addr", dmem_addr, 0);
        check("rst_dmem_wdata", dmem_wdata, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_reg_we", wb_reg_we, 0);
        check("rst_wb_cpsr_we", wb_cpsr_we, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_cpsr", wb_cpsr, 0);
        check("rst_mem_err", mem_err, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        issue(1, 0, 0, 0, 4'd3, 32'h0000_00AA, 32'h0, 32'h0, 32'h0, 0, 0);
        issue(0, 1, 0, 0, 4'd7, 32'h1111_1111, 32'hFFFF_FFF6, 32'h0, 32'h0, 0, 0);
        issue(1, 1, 0, 0, 4'd9, 32'h5555_0001, 32'h0000_0019, 32'h0, 32'h0, 0, 0);
        issue(0, 0, 0, 0, 4'd1, 32'h2222_2222, 32'hF, 32'h0, 32'h0, 0, 0);
        issue(0, 0, 1, 0, 4'd5, 32'h0, 32'h0, 32'h0, 32'hFFFF_FF00, 3, 0);
        issue(0, 0, 0, 1, 4'd2, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0000_0010, 1, 0);
        issue(1, 0, 0, 0, 4'd4, 32'h0BAD_CAFE, 32'h0, 32'h0, 32'h0, 0, 0);
        issue(0, 0, 1, 0, 4'd6, 32'h0, 32'h0, 32'h0, 32'hABC0_0010, 0, 0);
        issue(0, 0, 1, 1, 4'd8, 32'h0, 32'h0, 32'h1234_4321, 32'h0000_0010, 2, 0);
        issue(0, 0, 1, 0, 4'd10, 32'h0, 32'h0, 32'h0, 32'h0000_0003, TO - 1, 0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bubble();
            end else begin
                issue($urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      $urandom, $urandom, $urandom, $urandom,
                      ($urandom & 32'hFFC0_0000) | (($urandom % 2) << 21) | ($urandom % 8),
                      ($urandom_range(0, 9) == 0) ? TO - 1 : $urandom_range(0, 4), 0);
            end
        end
        drain();

        // Access that never completes.
        issue(0, 0, 1, 0, 4'd12, 32'h0, 32'h0, 32'h0, 32'h0000_0020, 0, 1);
        drain();
        repeat (3) @(negedge clk);
        check("mem_err_sticky", mem_err, 1);
        issue(1, 0, 0, 0, 4'd13, 32'h0000_0077, 32'h0, 32'h0, 32'h0, 0, 0);
        drain();

        // Reset in the middle of an access.
        issue(0, 0, 1, 0, 4'd14, 32'h0, 32'h0, 32'h0, 32'h0000_0030, 0, 1);
        ex_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_dmem_req", dmem_req, 0);
        check("rst_mid_stall", stall, 0);
        check("rst_mid_wb_valid", wb_valid, 0);
        check("rst_mid_mem_err", mem_err, 0);
        wb_q.delete();
        req_q.delete();
        err_model = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        issue(0, 0, 1, 0, 4'd15, 32'h0, 32'h0, 32'h0, 32'hFFFF_FF00, 1, 0);
        drain();
        check("final_mem_err", mem_err, 0);
        check("final_req_queue", req_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
